copy_light_cmd_driver: RTL and testbench
========================================

# copy_light_cmd_driver

Button-press generator for the four-level copy-light controller: accepts a target light level over a valid/ready command port and emits timed `button_up`/`button_down` pulses until the controller reaches that level. It sits on the driving side of the controller's button inputs, replacing hand-timed stimulus in benches and serving as the on-chip sequencer in integrated builds. An internal level model tracks the controller's state so the block knows which direction and how many presses to issue.

## Interface
- `PRESS_CYCLES`, 10, cycles each button pulse is held high (≥1)
- `GAP_CYCLES`, 10, cycles both buttons held low between pulses (≥1)
- `LVL_W`, 2, level width
- `LVL_MAX`, 3, highest level; levels are 0..LVL_MAX
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  target level request
- `cmd_lvl`  in  LVL_W  requested level; values > LVL_MAX clamp to LVL_MAX
- `cmd_ready`  out  1  high only in IDLE
- `button_up`  out  1  to controller up input
- `button_down`  out  1  to controller down input
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when the level matches the target
- `cur_lvl`  out  LVL_W  current level (model, or readback when configured)
- `light_lvl`  in  LVL_W  controller level readback; present only with `COPY_LIGHT_CMD_READBACK_EN`

## Operation
- FSM states: IDLE, DECIDE, PRESS, GAP.
- IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch the clamped target and go to DECIDE.
- DECIDE (1 cycle): if `cur_lvl == target`, assert `done` and go to IDLE. If target > cur, set dir=up; otherwise dir=down. Then go to PRESS.
- PRESS: assert the button for dir for exactly PRESS_CYCLES cycles. On the last cycle, the model steps cur±1, saturating at 0 and LVL_MAX. Then go to GAP.
- GAP: both buttons low for GAP_CYCLES cycles, then go to DECIDE.
- `button_up` and `button_down` are never high in the same cycle. Both are registered outputs.
- `cmd_valid` outside IDLE is ignored and not queued. A target equal to the current level yields `done` without any press.
- Reset values: state IDLE, `cur_lvl`=0, `button_up`=`button_down`=0, `done`=0, `busy`=0, `cmd_ready`=1, counters 0.
- Reset mid-press drops both buttons immediately (asynchronous) and zeroes the model. The controller must be reset together with this block so the model stays aligned.

## Timing
- Cycle 0 is the handshake cycle. Cycle 1 is DECIDE.
- Buttons are high in cycles 2..PRESS_CYCLES+1 and low for the next GAP_CYCLES cycles. The next DECIDE falls at cycle PRESS_CYCLES+GAP_CYCLES+2.
- A move of n levels: `done` at cycle 1 + n·(PRESS_CYCLES+GAP_CYCLES+1). `cmd_ready` returns high the following cycle.
- Back-to-back commands: the earliest new handshake is the cycle after `done`.

## Configuration
- `COPY_LIGHT_CMD_READBACK_EN` defined:
  - `light_lvl` port exists and is registered once internally.
  - DECIDE compares the target against the registered readback. `cur_lvl` mirrors that register, and the internal model is not built.
  - If a press has no effect, presses repeat until the readback matches.
- Undefined:
  - No `light_lvl` port; the open-loop saturating model is used.
  - Termination is guaranteed after at most LVL_MAX presses.

## Structure
- Package `copy_light_cmd_pkg`:
  - state enum (IDLE/DECIDE/PRESS/GAP)
  - dir enum (UP/DOWN)
  - default `LVL_MAX`, `LVL_W` constants
- Sub-module `copy_light_press_timer`: a loadable down-counter shared by PRESS and GAP. Load value PRESS_CYCLES or GAP_CYCLES; outputs a `last` flag on the final cycle.

## Test plan
- Reset, then cmd 3 from level 0 → exactly 3 `button_up` pulses of 10 cycles with 10-cycle gaps; `done` at cycle 64; `cur_lvl`=3; `button_down` never high.
- At level 3, cmd 1 → 2 `button_down` pulses; `cur_lvl`=1; `done` pulse width exactly 1.
- cmd equal to the current level (2→2) → `done` at cycle 1, no button activity.
- cmd_lvl out of range is not testable at `LVL_W`=2, `LVL_MAX`=3. Build with `LVL_W`=3, cmd 7 → clamps to `LVL_MAX`=3: 3 up-presses, `cur_lvl`=3.
- `cmd_valid` pulsed while busy → ignored; `cmd_ready`=0 throughout, original target completes.
- Assert `rst` during a PRESS → buttons low within the same cycle (asynchronous); `cur_lvl`=0; `cmd_ready`=1 after release.
- With `COPY_LIGHT_CMD_READBACK_EN`, hold `light_lvl` stuck at 1 for the first press, target 2 → a second up-press issued; `done` once `light_lvl`=2.

Source files
------------

// File: rtl/copy_light_cmd_pkg.sv
// Shared types and default sizing for the copy-light command driver.
// The FSM state and press-direction enums are used by the driver top
// and its press timer.
package copy_light_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_PRESS  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int DEF_LVL_W   = 2;
    localparam int DEF_LVL_MAX = 3;

endpackage

// File: rtl/copy_light_press_timer.sv
// Loadable down-counter that times both the button pulse and the gap
// after it. 'last' is high during the final cycle of a loaded interval.
module copy_light_press_timer
    import copy_light_cmd_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Load a new interval, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/copy_light_cmd_driver.sv
// Button-press sequencer for the four-level copy-light controller.
// Accepts a target level and issues timed button_up/button_down pulses
// until the tracked level matches it.
// Optional feature: define COPY_LIGHT_CMD_READBACK_EN to add the
// light_lvl readback port and close the loop on the controller's real
// level instead of the internal open-loop model.
module copy_light_cmd_driver
    import copy_light_cmd_pkg::*;
#(
    parameter int PRESS_CYCLES = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int LVL_W        = DEF_LVL_W,
    parameter int LVL_MAX      = DEF_LVL_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [LVL_W-1:0] cmd_lvl,
    output logic             cmd_ready,
    output logic             button_up,
    output logic             button_down,
    output logic             busy,
    output logic             done,
    output logic [LVL_W-1:0] cur_lvl
`ifdef COPY_LIGHT_CMD_READBACK_EN
    ,
    input  logic [LVL_W-1:0] light_lvl
`endif
);

    localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
    localparam logic [LVL_W-1:0] LVL_TOP    = LVL_W'(LVL_MAX);

    // Requests above the top level are treated as the top level.
    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
        return (lvl > LVL_TOP) ? LVL_TOP : lvl;
    endfunction

    // One button press moves the level by one, pinned at 0 and LVL_MAX.
    function automatic logic [LVL_W-1:0] step_lvl(input logic [LVL_W-1:0] lvl,
                                                   input dir_t           d);
        if (d == DIR_UP) begin
            return (lvl >= LVL_TOP) ? LVL_TOP : lvl + LVL_W'(1);
        end
        return (lvl == '0) ? '0 : lvl - LVL_W'(1);
    endfunction

    state_t           state;
    dir_t             dir;
    logic [LVL_W-1:0] target;
    // Value cur_lvl will hold in the next cycle; used when entering DECIDE
    // so that the registered done flag agrees with cur_lvl inside DECIDE.
    logic [LVL_W-1:0] lvl_ahead;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_last;

`ifdef COPY_LIGHT_CMD_READBACK_EN
    logic [LVL_W-1:0] light_lvl_q;

    // Single register stage on the controller's level readback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light_lvl_q <= '0;
        end else begin
            light_lvl_q <= light_lvl;
        end
    end

    assign lvl_ahead = light_lvl;
    assign cur_lvl   = light_lvl_q;
`else
    logic [LVL_W-1:0] model_lvl;

    // Open-loop copy of the controller level, stepped on the last press cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_lvl <= '0;
        end else if (state == ST_PRESS && timer_last) begin
            model_lvl <= step_lvl(model_lvl, button_up ? DIR_UP : DIR_DOWN);
        end
    end

    assign lvl_ahead = model_lvl;
    assign cur_lvl   = model_lvl;
`endif

    assign dir       = (target > cur_lvl) ? DIR_UP : DIR_DOWN;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Start the press interval out of DECIDE and the gap out of PRESS.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = PRESS_LOAD;
        if (state == ST_DECIDE && !done) begin
            timer_load = 1'b1;
            timer_val  = PRESS_LOAD;
        end else if (state == ST_PRESS && timer_last) begin
            timer_load = 1'b1;
            timer_val  = GAP_LOAD;
        end
    end

    copy_light_press_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    // Capture the clamped target at the handshake; it is data, not control.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && cmd_valid) begin
            target <= clamp_lvl(cmd_lvl);
        end
    end

    // Sequencer FSM; done is registered on entry to DECIDE and doubles as
    // the match decision inside DECIDE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            button_up   <= 1'b0;
            button_down <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        done  <= (clamp_lvl(cmd_lvl) == lvl_ahead);
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        button_up   <= (dir == DIR_UP);
                        button_down <= (dir == DIR_DOWN);
                        state       <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (timer_last) begin
                        button_up   <= 1'b0;
                        button_down <= 1'b0;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_last) begin
                        done  <= (target == lvl_ahead);
                        state <= ST_DECIDE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copy_light_cmd_driver.sv
// Scoreboard bench for copy_light_cmd_driver: each accepted command
// pushes its expected done time, final level and press counts; the
// monitor pops and compares when done pulses.
`timescale 1ns/1ps
module tb_copy_light_cmd_driver;

    localparam int P   = 10;
    localparam int G   = 10;
    localparam int LW  = 2;
    localparam int LM  = 3;
    localparam int PER = P + G + 1;
    localparam int P3  = 3;
    localparam int G3  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic [LW-1:0] cmd_lvl   = '0;
    logic          cmd_ready, button_up, button_down, busy, done;
    logic [LW-1:0] cur_lvl;

    logic          v3 = 1'b0;
    logic [2:0]    l3 = '0;
    logic          r3, bu3, bd3, busy3, d3;
    logic [2:0]    c3;

`ifdef COPY_LIGHT_CMD_READBACK_EN
    logic [LW-1:0] light_lvl;
    logic [LW-1:0] ctrl = '0;
    logic          pu = 1'b0, pd = 1'b0;
    bit            stuck = 1'b0;
    logic [2:0]    light3;
    logic [2:0]    ctrl3 = '0;
    logic          pu3 = 1'b0, pd3 = 1'b0;

    // Behavioural copy-light controller; 'stuck' swallows up-presses.
    always @(posedge clk) begin
        if (rst) begin
            ctrl <= '0; pu <= 1'b0; pd <= 1'b0;
        end else begin
            pu <= button_up; pd <= button_down;
            if (button_up && !pu && !stuck && ctrl < LW'(LM)) ctrl <= ctrl + LW'(1);
            if (button_down && !pd && ctrl > '0) ctrl <= ctrl - LW'(1);
        end
    end
    assign light_lvl = ctrl;

    always @(posedge clk) begin
        if (rst) begin
            ctrl3 <= '0; pu3 <= 1'b0; pd3 <= 1'b0;
        end else begin
            pu3 <= bu3; pd3 <= bd3;
            if (bu3 && !pu3 && ctrl3 < 3'd3) ctrl3 <= ctrl3 + 3'd1;
            if (bd3 && !pd3 && ctrl3 > 3'd0) ctrl3 <= ctrl3 - 3'd1;
        end
    end
    assign light3 = ctrl3;
`endif

    copy_light_cmd_driver #(
        .PRESS_CYCLES(P), .GAP_CYCLES(G), .LVL_W(LW), .LVL_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_lvl(cmd_lvl),
        .cmd_ready(cmd_ready), .button_up(button_up), .button_down(button_down),
        .busy(busy), .done(done), .cur_lvl(cur_lvl)
`ifdef COPY_LIGHT_CMD_READBACK_EN
        , .light_lvl(light_lvl)
`endif
    );

    copy_light_cmd_driver #(
        .PRESS_CYCLES(P3), .GAP_CYCLES(G3), .LVL_W(3), .LVL_MAX(3)
    ) dut_w3 (
        .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_lvl(l3),
        .cmd_ready(r3), .button_up(bu3), .button_down(bd3),
        .busy(busy3), .done(d3), .cur_lvl(c3)
`ifdef COPY_LIGHT_CMD_READBACK_EN
        , .light_lvl(light3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int done_off;
        int lvl;
        int ups;
        int dns;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   ref_lvl = 0;

    // Monitor state
    int cyc = 0, hs_cyc = 0, ups = 0, dns = 0, up_len = 0, dn_len = 0;
    bit prev_up = 0, prev_dn = 0, overlap = 0, chk_after = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            up_len = 0; dn_len = 0; prev_up = 0; prev_dn = 0; chk_after = 0;
        end else begin
            if (chk_after) begin
                check_eq("done_width", done, 0);
                check_eq("ready_after_done", cmd_ready, 1);
                chk_after = 0;
            end
            if (cmd_valid && cmd_ready) begin
                hs_cyc = cyc; ups = 0; dns = 0; overlap = 0;
            end
            if (button_up && button_down) overlap = 1;
            if (button_up && !prev_up) begin
                check_eq("up_start", cyc - hs_cyc, 2 + (ups + dns) * PER);
                ups++;
            end
            if (button_down && !prev_dn) begin
                check_eq("down_start", cyc - hs_cyc, 2 + (ups + dns) * PER);
                dns++;
            end
            if (button_up) up_len++;
            else if (up_len > 0) begin check_eq("up_width", up_len, P); up_len = 0; end
            if (button_down) dn_len++;
            else if (dn_len > 0) begin check_eq("down_width", dn_len, P); dn_len = 0; end
            if (done) begin
                check_eq("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("done_cycle", cyc - hs_cyc, e.done_off);
                    check_eq("cur_lvl", cur_lvl, e.lvl);
                    check_eq("up_presses", ups, e.ups);
                    check_eq("down_presses", dns, e.dns);
                    check_eq("no_overlap", overlap, 0);
                end
                chk_after = 1;
            end
            prev_up = button_up;
            prev_dn = button_down;
        end
    end

    // Issue one command from a posedge+1 point; extra = presses the
    // controller will swallow.
    task automatic send_cmd(input int lvl, input int extra);
        int   t, tgt, n;
        exp_t x;
        t = 0;
        while (!cmd_ready && t < 1000) begin @(posedge clk); #1; t++; end
        check_eq("ready_before_cmd", cmd_ready, 1);
        tgt = (lvl > LM) ? LM : lvl;
        n   = (tgt > ref_lvl) ? tgt - ref_lvl : ref_lvl - tgt;
        x.done_off = 1 + (n + extra) * PER;
        x.lvl      = tgt;
        x.ups      = (tgt > ref_lvl) ? n + extra : 0;
        x.dns      = (tgt < ref_lvl) ? n : 0;
        sb_q.push_back(x);
        ref_lvl   = tgt;
        cmd_valid = 1'b1;
        cmd_lvl   = LW'(lvl);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
        check_eq("done_timeout", sb_q.size(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ups3, dns3, done_at;
        bit p3;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_up", button_up, 0);
        check_eq("rst_down", button_down, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_lvl", cur_lvl, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0 -> 3, 3 -> 1, 1 -> 2, then 2 -> 2 (no presses)
        send_cmd(3, 0); wait_done();
        send_cmd(1, 0); wait_done();
        send_cmd(2, 0); wait_done();
        send_cmd(2, 0); wait_done();

        // New command while busy must be ignored
        send_cmd(0, 0);
        repeat (5) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_lvl   = 2'd3;
        check_eq("busy_ready_low", cmd_ready, 0);
        check_eq("busy_high", busy, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done();
        repeat (30) @(posedge clk);
        #1;
        check_eq("ignored_not_queued", busy, 0);

        // Asynchronous reset in the middle of the second up-press
        send_cmd(3, 0);
        t = 0;
        while (ups < 2 && t < 200) begin @(posedge clk); #1; t++; end
        check_eq("reached_second_press", ups, 2);
        check_eq("pressing_before_rst", button_up, 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        ref_lvl = 0;
        #1;
        check_eq("async_rst_up", button_up, 0);
        check_eq("async_rst_down", button_down, 0);
        check_eq("async_rst_lvl", cur_lvl, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_lvl", cur_lvl, 0);
        send_cmd(2, 0); wait_done();

        // Out-of-range request on the 3-bit instance clamps to level 3
        check_eq("w3_ready", r3, 1);
        v3 = 1'b1;
        l3 = 3'd7;
        @(posedge clk); #1;
        v3 = 1'b0;
        ups3 = 0; dns3 = 0; done_at = -1; p3 = 0;
        for (int c = 1; c < 200; c++) begin
            if (bu3 && !p3) ups3++;
            if (bd3) dns3++;
            p3 = bu3;
            if (d3) begin done_at = c; break; end
            @(posedge clk); #1;
        end
        check_eq("w3_done_cycle", done_at, 1 + 3 * (P3 + G3 + 1));
        check_eq("w3_cur_lvl", c3, 3);
        check_eq("w3_up_presses", ups3, 3);
        check_eq("w3_no_down", dns3, 0);
        @(posedge clk); #1;
        check_eq("w3_idle", busy3, 0);

`ifdef COPY_LIGHT_CMD_READBACK_EN
        // First up-press has no effect; driver must press again
        send_cmd(1, 0); wait_done();
        stuck = 1'b1;
        send_cmd(2, 1);
        t = 0;
        while (ups < 1 && t < 100) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #1;
        stuck = 1'b0;
        check_eq("stuck_lvl", cur_lvl, 1);
        wait_done();
        check_eq("readback_final", light_lvl, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
